// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter onto one shared SDRAM port; one burst outstanding at a time.
// Define SDRAM_PORT_ARBITER_STATS_EN to build the debug_value0..2 statistics counters.
module sdram_port_arbiter #(
    parameter int unsigned MAX_STARVE = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [28:0] m0_address,
    input  logic [7:0]  m0_burstcount,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [63:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [28:0] m1_address,
    input  logic [7:0]  m1_burstcount,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [63:0] m1_writedata,
    input  logic [7:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [63:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [28:0] s_address,
    output logic [7:0]  s_burstcount,
    output logic        s_read,
    output logic        s_write,
    output logic [63:0] s_writedata,
    output logic [7:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [63:0] s_readdata,
    input  logic        s_readdatavalid,
    output logic [31:0] debug_value0,
    output logic [31:0] debug_value1,
    output logic [31:0] debug_value2
);
    typedef enum logic [1:0] {StIdle, StCmd, StRdata, StWdata} state_e;

    localparam logic [7:0] StarveMax = 8'(MAX_STARVE);

    state_e     r_state, w_state_next;
    logic       r_owner, w_owner_next;  // 0 = m0, 1 = m1
    logic [7:0] r_starve, w_starve_next;
    logic [7:0] r_remaining, w_remaining_next;

    logic       w_m0_req, w_m1_req, w_any_req, w_grant_m1;
    logic       w_active, w_own_read, w_own_write, w_accept;
    logic [7:0] w_bc_raw, w_bc;

    assign w_m0_req   = m0_read;
    assign w_m1_req   = m1_read | m1_write;
    assign w_any_req  = w_m0_req | w_m1_req;
    assign w_grant_m1 = w_m1_req & (~w_m0_req | (r_starve == StarveMax));

    assign w_active    = (r_state == StCmd) || (r_state == StWdata);
    assign w_bc_raw    = r_owner ? m1_burstcount : m0_burstcount;
    assign w_bc        = (w_bc_raw == 8'd0) ? 8'd1 : w_bc_raw;
    // m1 asserting read and write together is treated as a write
    assign w_own_write = r_owner & m1_write;
    assign w_own_read  = r_owner ? (m1_read & ~m1_write) : m0_read;
    assign w_accept    = (s_read | s_write) & ~s_waitrequest;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_starve    <= 8'd0;
            r_remaining <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_starve    <= w_starve_next;
            r_remaining <= w_remaining_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_starve_next    = r_starve;
        w_remaining_next = r_remaining;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StCmd;
                    w_owner_next = w_grant_m1;
                    if (w_grant_m1) begin
                        w_starve_next = 8'd0;
                    end else if (w_m1_req && (r_starve < StarveMax)) begin
                        w_starve_next = r_starve + 8'd1;
                    end
                end
            end
            StCmd: begin
                if (w_accept) begin
                    if (w_own_write) begin
                        if (w_bc == 8'd1) begin
                            w_state_next = StIdle;
                        end else begin
                            w_state_next     = StWdata;
                            w_remaining_next = w_bc - 8'd1;
                        end
                    end else begin
                        w_state_next     = StRdata;
                        w_remaining_next = w_bc;
                    end
                end
            end
            StRdata: begin
                if (s_readdatavalid) begin
                    w_remaining_next = r_remaining - 8'd1;
                    if (r_remaining <= 8'd1) w_state_next = StIdle;
                end
            end
            StWdata: begin
                if (w_accept) begin
                    w_remaining_next = r_remaining - 8'd1;
                    if (r_remaining <= 8'd1) w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        s_address        = r_owner ? m1_address : m0_address;
        s_burstcount     = w_bc_raw;
        s_writedata      = m1_writedata;
        s_byteenable     = r_owner ? m1_byteenable : 8'hFF;
        s_read           = 1'b0;
        s_write          = 1'b0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (r_state == StCmd) s_read = w_own_read;
        if (w_active) begin
            s_write = w_own_write;
            if (r_owner) m1_waitrequest = s_waitrequest;
            else         m0_waitrequest = s_waitrequest;
        end
        if (r_state == StRdata) begin
            if (r_owner) m1_readdatavalid = s_readdatavalid;
            else         m0_readdatavalid = s_readdatavalid;
        end
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

`ifdef SDRAM_PORT_ARBITER_STATS_EN
    logic [31:0] r_m0_grants, r_m1_grants;
    logic [23:0] r_m1_blocked;
    logic [7:0]  r_stray;
    logic        w_m1_blocked;

    // m1 only counts as owner while a burst is actually in progress
    assign w_m1_blocked = w_m1_req & ~(r_owner & (r_state != StIdle));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_grants  <= 32'd0;
            r_m1_grants  <= 32'd0;
            r_m1_blocked <= 24'd0;
            r_stray      <= 8'd0;
        end else begin
            if ((r_state == StIdle) && w_any_req) begin
                if (w_grant_m1) r_m1_grants <= r_m1_grants + 32'd1;
                else            r_m0_grants <= r_m0_grants + 32'd1;
            end
            if (w_m1_blocked && (r_m1_blocked != 24'hFFFFFF)) r_m1_blocked <= r_m1_blocked + 24'd1;
            if (s_readdatavalid && (r_state != StRdata) && (r_stray != 8'hFF)) begin
                r_stray <= r_stray + 8'd1;
            end
        end
    end

    assign debug_value0 = r_m0_grants;
    assign debug_value1 = r_m1_grants;
    assign debug_value2 = {r_stray, r_m1_blocked};
`else
    assign debug_value0 = 32'd0;
    assign debug_value1 = 32'd0;
    assign debug_value2 = 32'd0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed bursts, starvation order, reset, stats.
module tb_sdram_port_arbiter;
    localparam int unsigned MaxStarve = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [28:0] m0_address, m1_address, s_address;
    logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic        m0_read, m1_read, m1_write;
    logic [63:0] m1_writedata, s_writedata, s_readdata, m0_readdata, m1_readdata;
    logic [7:0]  m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [31:0] debug_value0, debug_value1, debug_value2;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_arbiter #(.MAX_STARVE(MaxStarve)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_burstcount    (m0_burstcount),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_burstcount    (m1_burstcount),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_burstcount     (s_burstcount),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .debug_value0     (debug_value0),
        .debug_value1     (debug_value1),
        .debug_value2     (debug_value2)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        m0_read = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_burstcount = 8'd1; m1_burstcount = 8'd1;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_read = 1; m1_read = 1; m1_write = 1;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({s_read, s_write, m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest}
            !== 6'b000011) begin
            n_err++;
            $display("FAIL reset_outputs: got rd/wr/rdv0/rdv1/wr0/wr1=%b%b%b%b%b%b required 000011",
                     s_read, s_write, m0_readdatavalid, m1_readdatavalid, m0_waitrequest,
                     m1_waitrequest);
        end
        n_cmp++;
        if ({debug_value0, debug_value1, debug_value2} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_debug: got %h %h %h required 0 0 0",
                     debug_value0, debug_value1, debug_value2);
        end
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b1;
    endtask

    // Model: one burst is exactly max(bc,1) accepted beats (write) or data beats (read),
    // forwarded only to the requesting master, then the arbiter is idle again.
    task automatic run_burst(input bit mst, input bit wr, input bit rd_too,
                             input logic [7:0] bc, input int unsigned wpct);
        int          beats, done, cyc;
        logic [28:0] addr;
        logic        own_wait, oth_wait, own_rdv, oth_rdv;
        logic [63:0] own_data;
        beats = (bc == 8'd0) ? 1 : int'(bc);
        addr  = 29'($urandom);
        @(negedge clock);
        if (!mst) begin
            m0_read = 1; m0_address = addr; m0_burstcount = bc;
        end else begin
            m1_write = wr; m1_read = wr ? rd_too : 1'b1;
            m1_address = addr; m1_burstcount = bc;
            m1_writedata = {$urandom, $urandom}; m1_byteenable = 8'($urandom);
        end
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
        #1;
        n_cmp++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0
            || s_write !== 1'b0) begin
            n_err++;
            $display("FAIL idle_cycle: got wr0=%b wr1=%b s_read=%b s_write=%b required 1 1 0 0",
                     m0_waitrequest, m1_waitrequest, s_read, s_write);
        end
        done = 0; cyc = 0;
        while (done < (wr ? beats : 1) && cyc < 200) begin
            @(negedge clock);
            s_waitrequest = ($urandom_range(99) < wpct);
            if (wr) begin
                m1_writedata = {$urandom, $urandom}; m1_byteenable = 8'($urandom);
            end
            #1;
            own_wait = mst ? m1_waitrequest : m0_waitrequest;
            oth_wait = mst ? m0_waitrequest : m1_waitrequest;
            n_cmp++;
            if (s_read !== !wr || s_write !== wr || own_wait !== s_waitrequest
                || oth_wait !== 1'b1 || s_address !== addr || s_burstcount !== bc) begin
                n_err++;
                $display("FAIL cmd_beat: got rd=%b wr=%b own_wait=%b oth_wait=%b addr=%h bc=%0d required rd=%b wr=%b own_wait=%b oth_wait=1 addr=%h bc=%0d",
                         s_read, s_write, own_wait, oth_wait, s_address, s_burstcount,
                         !wr, wr, s_waitrequest, addr, bc);
            end
            if (wr) begin
                n_cmp++;
                if (s_writedata !== m1_writedata || s_byteenable !== m1_byteenable) begin
                    n_err++;
                    $display("FAIL write_data: got %h/%h required %h/%h",
                             s_writedata, s_byteenable, m1_writedata, m1_byteenable);
                end
            end
            if (!s_waitrequest) done++;
            cyc++;
        end
        if (!wr) begin
            done = 0;
            while (done < beats && cyc < 400) begin
                @(negedge clock);
                m0_read = 0; m1_read = 0;
                s_readdatavalid = ($urandom_range(99) >= wpct);
                s_readdata = {$urandom, $urandom};
                s_waitrequest = 1'($urandom);
                #1;
                own_rdv  = mst ? m1_readdatavalid : m0_readdatavalid;
                oth_rdv  = mst ? m0_readdatavalid : m1_readdatavalid;
                own_data = mst ? m1_readdata : m0_readdata;
                n_cmp++;
                if (own_rdv !== s_readdatavalid || oth_rdv !== 1'b0 || own_data !== s_readdata
                    || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0) begin
                    n_err++;
                    $display("FAIL read_beat: got own_rdv=%b oth_rdv=%b data=%h wr0=%b wr1=%b s_read=%b required %b 0 %h 1 1 0",
                             own_rdv, oth_rdv, own_data, m0_waitrequest, m1_waitrequest, s_read,
                             s_readdatavalid, s_readdata);
                end
                if (s_readdatavalid) done++;
                cyc++;
            end
        end
        if (cyc >= 400 || (wr && cyc >= 200)) begin
            n_err++;
            $display("FAIL burst_timeout: got %0d cycles required fewer", cyc);
        end
        // Back in IDLE: waitrequest stays high and a stray readdatavalid is not forwarded
        @(negedge clock);
        m0_read = 0; m1_read = 0; m1_write = 0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b1;
        #1;
        n_cmp++;
        if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b1100) begin
            n_err++;
            $display("FAIL burst_end_idle: got wr0/wr1/rdv0/rdv1=%b%b%b%b required 1100",
                     m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid);
        end
    endtask

    task automatic test_write_burst();
        run_burst(1'b1, 1'b1, 1'b0, 8'd4, 50);
    endtask

    task automatic test_read_burst();
        run_burst(1'b0, 1'b0, 1'b0, 8'd8, 40);
    endtask

    task automatic test_rw_conflict();
        run_burst(1'b1, 1'b1, 1'b1, 8'd0, 30);
    endtask

    task automatic test_starvation();
        int   k, cyc;
        bit   pending, got_m1, exp_m1;
        logic [28:0] a0, a1;
        a0 = 29'h0AAA_0000; a1 = 29'h1555_0000;
        @(negedge clock);
        m0_read = 1; m1_read = 1; m1_write = 0;
        m0_address = a0; m1_address = a1; m0_burstcount = 8'd1; m1_burstcount = 8'd1;
        s_waitrequest = 1'b0;
        pending = 0; k = 0; cyc = 0;
        while (k < 12 && cyc < 200) begin
            if (cyc > 0) @(negedge clock);
            s_readdatavalid = pending;
            pending = 0;
            #1;
            if (!m0_waitrequest || !m1_waitrequest) begin
                got_m1 = !m1_waitrequest;
                exp_m1 = ((k % 4) == 3);
                n_cmp++;
                if (got_m1 !== exp_m1 || (!m0_waitrequest && !m1_waitrequest)
                    || s_address !== (exp_m1 ? a1 : a0)) begin
                    n_err++;
                    $display("FAIL grant_order[%0d]: got m1=%b wr0=%b wr1=%b addr=%h required m1=%b",
                             k, got_m1, m0_waitrequest, m1_waitrequest, s_address, exp_m1);
                end
                k++;
                pending = 1;
            end
            cyc++;
        end
        if (k < 12) begin
            n_err++;
            $display("FAIL grant_timeout: got %0d grants required 12", k);
        end
        @(negedge clock);
        m0_read = 0; m1_read = 0; s_readdatavalid = 1'b1;
        @(negedge clock);
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_random();
        bit mst, wr;
        for (int i = 0; i < 20; i++) begin
            mst = 1'($urandom_range(1));
            wr  = mst ? 1'($urandom_range(1)) : 1'b0;
            run_burst(mst, wr, 1'($urandom_range(1)), 8'($urandom_range(0, 6)),
                      $urandom_range(0, 60));
        end
    endtask

    task automatic test_reset_mid_burst();
        int done;
        @(negedge clock);
        m0_read = 1; m0_burstcount = 8'd8; s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
        @(negedge clock);            // CMD: accepted this cycle
        @(negedge clock);
        m0_read = 0;
        done = 0;
        while (done < 2) begin
            s_readdatavalid = 1'b1;
            done++;
            @(negedge clock);
        end
        m0_read = 1; m0_burstcount = 8'd1;
        #1;
        n_cmp++;
        if (m0_readdatavalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_burst_rdv: got %b required 1", m0_readdatavalid);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({m0_readdatavalid, m1_readdatavalid, s_read, s_write, m0_waitrequest, m1_waitrequest}
            !== 6'b000011 || debug_value0 !== 32'd0 || debug_value1 !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: got rdv0/rdv1/rd/wr/wr0/wr1=%b%b%b%b%b%b dbg0=%0d dbg1=%0d required 000011 0 0",
                     m0_readdatavalid, m1_readdatavalid, s_read, s_write, m0_waitrequest,
                     m1_waitrequest, debug_value0, debug_value1);
        end
        @(negedge clock);
        reset_n = 1'b1; s_readdatavalid = 1'b0;
        #1;
        n_cmp++;
        if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got wr0=%b s_read=%b required 1 0",
                     m0_waitrequest, s_read);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (m0_waitrequest !== 1'b0 || s_read !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_grant: got wr0=%b s_read=%b required 0 1",
                     m0_waitrequest, s_read);
        end
        @(negedge clock);
        m0_read = 0; s_readdatavalid = 1'b1;
        @(negedge clock);
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_stats();
        logic [31:0] exp0, exp1, exp2_hi;
        @(negedge clock);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) run_burst(1'b0, 1'b0, 1'b0, 8'($urandom_range(1, 3)), 30);
        for (int i = 0; i < 2; i++) run_burst(1'b1, 1'b1, 1'b0, 8'd2, 30);
        @(negedge clock);
        s_readdatavalid = 1'b0;
        #1;
`ifdef SDRAM_PORT_ARBITER_STATS_EN
        exp0 = 32'd5; exp1 = 32'd2; exp2_hi = 32'd7;
`else
        exp0 = 32'd0; exp1 = 32'd0; exp2_hi = 32'd0;
`endif
        n_cmp++;
        if (debug_value0 !== exp0 || debug_value1 !== exp1) begin
            n_err++;
            $display("FAIL stats_grants: got %0d/%0d required %0d/%0d",
                     debug_value0, debug_value1, exp0, exp1);
        end
        n_cmp++;
        if (32'(debug_value2[31:24]) !== exp2_hi) begin
            n_err++;
            $display("FAIL stats_stray: got %0d required %0d", debug_value2[31:24], exp2_hi);
        end
`ifndef SDRAM_PORT_ARBITER_STATS_EN
        n_cmp++;
        if (debug_value2 !== 32'd0) begin
            n_err++;
            $display("FAIL stats_disabled: got %h required 0", debug_value2);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_rw_conflict();
        test_starvation();
        test_random();
        test_reset_mid_burst();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
